// File: rtl/fei4_frame_symbol_gen_if.sv
// ---------------------------------------------------------------------------
// fei4_frame_symbol_gen_if
// Bundles the readout-FIFO handshake and the symbol stream towards the
// 8b10b encoder. The "master" modport is the frame/symbol generator and the
// "slave" modport is its environment (FIFO + encoder + control).
// ---------------------------------------------------------------------------
interface fei4_frame_symbol_gen_if #(
    parameter int DATA_WIDTH = 24
);
    logic                  enable;
    logic                  emptyFifo;
    logic [DATA_WIDTH-1:0] data;
    logic                  readFifo;
    logic [7:0]            sym;
    logic                  sym_k;
    logic                  sym_strobe;
    logic                  frame_active;

    modport master (
        input  enable,
        input  emptyFifo,
        input  data,
        output readFifo,
        output sym,
        output sym_k,
        output sym_strobe,
        output frame_active
    );

    modport slave (
        output enable,
        output emptyFifo,
        output data,
        input  readFifo,
        input  sym,
        input  sym_k,
        input  sym_strobe,
        input  frame_active
    );
endinterface

// File: rtl/fei4_frame_symbol_gen.sv
// ---------------------------------------------------------------------------
// fei4_frame_symbol_gen
// Output-data path of the FE-I4 emulator. Pulls DATA_WIDTH-bit hit records
// from the readout FIFO, splits them MSB byte first and wraps groups of up to
// MAX_RECORDS records into frames delimited by SOF_K / EOF_K. One symbol
// (plus K flag) is produced every SYM_PERIOD clocks, marked by sym_strobe.
//
// Optional build macro: FRAME_TRAILER_EN
//   When defined, a trailer data symbol carrying the 8-bit frame counter
//   (value before increment) is inserted between the last data byte and EOF.
//   When undefined, DATA goes straight to EOF; the frame counter still runs.
// ---------------------------------------------------------------------------
module fei4_frame_symbol_gen #(
    parameter int         DATA_WIDTH  = 24,
    parameter int         SYM_PERIOD  = 10,
    parameter int         MAX_RECORDS = 16,
    parameter logic [7:0] IDLE_K      = 8'h3C,
    parameter logic [7:0] SOF_K       = 8'hFC,
    parameter logic [7:0] EOF_K       = 8'hDC
) (
    input  logic clock,
    input  logic reset,
    fei4_frame_symbol_gen_if.master bus
);

    // -----------------------------------------------------------------------
    // Derived sizes
    // -----------------------------------------------------------------------
    localparam int NB = DATA_WIDTH / 8;
    localparam int TW = (SYM_PERIOD  > 1) ? $clog2(SYM_PERIOD)  : 1;
    localparam int IW = (NB          > 1) ? $clog2(NB)          : 1;
    localparam int RW = (MAX_RECORDS > 1) ? $clog2(MAX_RECORDS) : 1;

    localparam logic [TW-1:0] TICK_VAL = TW'(SYM_PERIOD - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);
    localparam logic [RW-1:0] LAST_REC = RW'(MAX_RECORDS - 1);

    // -----------------------------------------------------------------------
    // Parameter sanity (elaboration time only)
    // -----------------------------------------------------------------------
    if ((DATA_WIDTH < 8) || ((DATA_WIDTH % 8) != 0)) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of 8 and at least 8");
    end
    if (SYM_PERIOD < 3) begin : g_bad_period
        $error("SYM_PERIOD must be at least 3 so a record lands before the next tick");
    end
    if (MAX_RECORDS < 1) begin : g_bad_max
        $error("MAX_RECORDS must be at least 1");
    end

    // -----------------------------------------------------------------------
    // Frame state machine encoding
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DATA    = 2'd1,
`ifdef FRAME_TRAILER_EN
        ST_TRAILER = 2'd3,
`endif
        ST_EOF     = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Byte selection: idx 0 is the most significant byte of the record.
    // -----------------------------------------------------------------------
    function automatic logic [7:0] select_byte(
        input logic [DATA_WIDTH-1:0] rec,
        input logic [IW-1:0]         idx
    );
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < NB; i++) begin
            if (idx == IW'(NB - 1 - i)) begin
                b = rec[8*i +: 8];
            end
        end
        return b;
    endfunction

    // -----------------------------------------------------------------------
    // Internal state
    // -----------------------------------------------------------------------
    logic [TW-1:0]         timer_r;
    logic                  tick_s;
    logic                  read_pend_r;
    logic [DATA_WIDTH-1:0] record_r;

    state_t                state_r;
    logic [IW-1:0]         idx_r;
    logic [RW-1:0]         rec_cnt_r;
    logic [7:0]            frame_cnt_r;

    logic [7:0]            sym_r;
    logic                  sym_k_r;
    logic                  strobe_r;
    logic                  read_fifo_r;
    logic                  active_r;

    // A tick marks the last clock of each symbol period; all FSM decisions
    // and the sampling of enable/emptyFifo happen only on that clock.
    assign tick_s = (timer_r == TICK_VAL);

    // Symbol period timer: counts 0..SYM_PERIOD-1 and wraps.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer_r <= '0;
        end else if (tick_s) begin
            timer_r <= '0;
        end else begin
            timer_r <= timer_r + TW'(1);
        end
    end

    // Record latch: FIFO data is valid one clock after the read pulse, so the
    // pulse is delayed once and used as the capture enable.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            read_pend_r <= 1'b0;
            record_r    <= '0;
        end else begin
            read_pend_r <= read_fifo_r;
            if (read_pend_r) begin
                record_r <= bus.data;
            end else begin
                record_r <= record_r;
            end
        end
    end

    // Frame FSM with registered symbol, strobe, read pulse and frame flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            idx_r       <= '0;
            rec_cnt_r   <= '0;
            frame_cnt_r <= 8'h00;
            sym_r       <= IDLE_K;
            sym_k_r     <= 1'b1;
            strobe_r    <= 1'b0;
            read_fifo_r <= 1'b0;
            active_r    <= 1'b0;
        end else begin
            // Strobe and read request are single-clock pulses.
            strobe_r    <= 1'b0;
            read_fifo_r <= 1'b0;
            if (tick_s) begin
                strobe_r <= 1'b1;
                case (state_r)
                    ST_IDLE: begin
                        if (bus.enable && !bus.emptyFifo) begin
                            sym_r       <= SOF_K;
                            sym_k_r     <= 1'b1;
                            read_fifo_r <= 1'b1;
                            rec_cnt_r   <= '0;
                            idx_r       <= '0;
                            active_r    <= 1'b1;
                            state_r     <= ST_DATA;
                        end else begin
                            sym_r    <= IDLE_K;
                            sym_k_r  <= 1'b1;
                            active_r <= 1'b0;
                            state_r  <= ST_IDLE;
                        end
                    end

                    ST_DATA: begin
                        sym_r   <= select_byte(record_r, idx_r);
                        sym_k_r <= 1'b0;
                        if (idx_r != LAST_IDX) begin
                            idx_r <= idx_r + IW'(1);
                        end else if (!bus.emptyFifo && (rec_cnt_r < LAST_REC)) begin
                            // Next record continues the same frame; it is
                            // latched well before the following tick.
                            read_fifo_r <= 1'b1;
                            rec_cnt_r   <= rec_cnt_r + RW'(1);
                            idx_r       <= '0;
                        end else begin
                            // Records are never split: the frame closes only
                            // after the final byte of the current record.
`ifdef FRAME_TRAILER_EN
                            state_r <= ST_TRAILER;
`else
                            state_r <= ST_EOF;
`endif
                        end
                    end

`ifdef FRAME_TRAILER_EN
                    ST_TRAILER: begin
                        sym_r   <= frame_cnt_r;
                        sym_k_r <= 1'b0;
                        state_r <= ST_EOF;
                    end
`endif

                    ST_EOF: begin
                        // frame_active stays high through the EOF symbol and
                        // is cleared by the next IDLE decision.
                        sym_r       <= EOF_K;
                        sym_k_r     <= 1'b1;
                        frame_cnt_r <= frame_cnt_r + 8'd1;
                        state_r     <= ST_IDLE;
                    end

                    default: begin
                        sym_r    <= IDLE_K;
                        sym_k_r  <= 1'b1;
                        active_r <= 1'b0;
                        state_r  <= ST_IDLE;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs come straight from registers
    // -----------------------------------------------------------------------
    assign bus.sym          = sym_r;
    assign bus.sym_k        = sym_k_r;
    assign bus.sym_strobe   = strobe_r;
    assign bus.readFifo     = read_fifo_r;
    assign bus.frame_active = active_r;

endmodule
